parity_word_rx: RTL

Receive side of the 32-bit word/parity link driven by `Device`. Accepts a word as four byte beats (LSB byte first) followed by one parity beat. Checks the received parity against even-XOR parity recomputed over the word. Presents the reassembled word with a mismatch flag on a valid/ready output, and keeps a saturating error count.

---
 rtl/parity_link_pkg.sv | 18 +
 rtl/parity_word_rx.sv | 117 +++++++++++
 2 files changed

// File: rtl/parity_link_pkg.sv
// Shared definitions for the 32-bit word/parity link: FSM states, widths
// and the even-XOR parity rule used on both ends of the link.
package parity_link_pkg;

  localparam int BEAT_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    HOLD    = 2'd2
  } state_t;

  function automatic logic word_parity(input logic [WORD_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/parity_word_rx.sv
// Link receiver: assembles byte beats (LSB first) into a word, checks the
// trailing parity beat and presents word + mismatch flag on a valid/ready port.
module parity_word_rx
  import parity_link_pkg::*;
#(
  parameter int NUM_BYTES = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [BEAT_W-1:0]           byte_in,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic [BEAT_W*NUM_BYTES-1:0] word_out,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        parity_err,
  output logic [ERR_CNT_W-1:0]        err_count
);

  localparam int W     = BEAT_W * NUM_BYTES;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    index_reg;
  logic                xor_reg;
  logic [BEAT_W-1:0]   lane_reg [NUM_BYTES];
  logic [W-1:0]        asm_word;
  logic                accept;
  logic                last_lane;
  logic                collect_acc;
  logic                parity_acc;
  logic                hold_done;

  assign accept      = byte_valid && byte_ready;
  assign last_lane   = (index_reg == IDX_W'(NUM_BYTES - 1));
  assign collect_acc = accept && (state_reg == COLLECT);
  assign parity_acc  = accept && (state_reg == PARITY);
  assign hold_done   = !flush && (state_reg == HOLD) && word_ready;

  // One register per byte lane; only the lane selected by the index loads.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg[gi] <= '0;
        end else if (collect_acc && (index_reg == IDX_W'(gi))) begin
          lane_reg[gi] <= byte_in;
        end
      end
      assign asm_word[gi*BEAT_W +: BEAT_W] = lane_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = COLLECT;
    end else begin
      case (state_reg)
        COLLECT: if (accept && last_lane) state_next = PARITY;
        PARITY:  if (accept)              state_next = HOLD;
        HOLD:    if (word_ready)          state_next = COLLECT;
        default:                          state_next = COLLECT;
      endcase
    end
  end

  // flush masks the handshake so a beat offered alongside it is dropped.
  always_comb begin
    byte_ready = !flush && (state_reg != HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_reg  <= '0;
      xor_reg    <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      parity_err <= 1'b0;
      err_count  <= '0;
    end else if (flush) begin
      index_reg  <= '0;
      xor_reg    <= 1'b0;
      word_valid <= 1'b0;
    end else begin
      if (collect_acc) begin
        index_reg <= last_lane ? '0 : index_reg + 1'b1;
        xor_reg   <= xor_reg ^ (^byte_in);
      end
      if (parity_acc) begin
        word_out   <= asm_word;
        parity_err <= byte_in[0] ^ xor_reg;
        word_valid <= 1'b1;
        if ((byte_in[0] ^ xor_reg) && !(&err_count)) begin
          err_count <= err_count + 1'b1;
        end
      end
      if (hold_done) begin
        word_valid <= 1'b0;
        index_reg  <= '0;
        xor_reg    <= 1'b0;
      end
    end
  end

endmodule
